// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cpu_mem_pkg                                            |
// | Description : Shared types and helpers for the CPU memory stage:     |
// |               access-size/extension selector, memory-stage FSM       |
// |               states, byte-enable and alignment helpers.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_mem_pkg;

  // Access size and load extension selector, encoded as driven by decode.
  typedef enum logic [1:0] {
    EXT_WORD   = 2'b00,
    EXT_BYTE_U = 2'b01,
    EXT_BYTE_S = 2'b10,
    EXT_HALF_S = 2'b11
  } extnd_sel_t;

  // Memory-stage controller states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Number of byte lanes on the data-memory port.
  localparam int c_BE_W = 4;

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [c_BE_W-1:0] byte_enables(input extnd_sel_t sel,
                                                     input logic [1:0] off);
    logic [c_BE_W-1:0] be;
    case (sel)
      EXT_WORD:   be = 4'b1111;
      EXT_HALF_S: be = off[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  // Words must sit on a 4-byte boundary, halves on a 2-byte boundary.
  function automatic logic is_misaligned(input extnd_sel_t sel,
                                         input logic [1:0] off);
    logic mis;
    case (sel)
      EXT_WORD:   mis = (off != 2'b00);
      EXT_HALF_S: mis = off[0];
      default:    mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : mem_stage_ctrl_if                                      |
// | Description : Request/acknowledge data-memory port between the       |
// |               memory-stage controller (master) and memory (slave).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface mem_stage_ctrl_if #(
  parameter int DW = 32
);
  logic          mem_req_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_extend                                            |
// | Description : Selects the addressed byte/half lane of a read word    |
// |               and zero- or sign-extends it to DW bits. Purely        |
// |               combinational so forwarding logic can share it.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_extend
  import cpu_mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  wire  [DW-1:0] rdata,
  input  wire  [1:0]    offset,
  input  wire  [1:0]    extnd_sel,
  output logic [DW-1:0] ext_data
);

  extnd_sel_t w_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sel = extnd_sel_t'(extnd_sel);

  // Lane selection then extension according to the access size.
  always_comb begin
    w_byte   = rdata[{offset, 3'b000} +: 8];
    w_half   = rdata[{offset[1], 4'b0000} +: 16];
    ext_data = rdata;
    case (w_sel)
      EXT_WORD:   ext_data = rdata;
      EXT_BYTE_U: ext_data = {{(DW-8){1'b0}}, w_byte};
      EXT_BYTE_S: ext_data = {{(DW-8){w_byte[7]}}, w_byte};
      EXT_HALF_S: ext_data = {{(DW-16){w_half[15]}}, w_half};
      default:    ext_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_stage_ctrl                                         |
// | Description : CPU pipeline memory-stage controller. Issues loads and |
// |               stores on a req/ack memory port, stalls upstream while |
// |               an access is outstanding, extends load data and drives |
// |               a registered writeback bundle. Misaligned accesses,    |
// |               conflicting load+store and ack timeouts raise a sticky |
// |               error flag.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mem_stage_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DW      = 32,
  parameter int RW      = 4,
  parameter int TIMEOUT = 16
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              wmem_i,
  input  wire              rmem_i,
  input  wire              wreg_i,
  input  wire  [DW-1:0]    addr_i,
  input  wire  [DW-1:0]    wdata_i,
  input  wire  [RW-1:0]    dest_i,
  input  wire  [1:0]       extnd_sel_i,
  output logic             stall_o,
  mem_stage_ctrl_if.master mem,
  output logic             wb_wreg_o,
  output logic [RW-1:0]    wb_dest_o,
  output logic [DW-1:0]    wb_data_o,
  output logic             err_o
);

  // Counter must be able to hold TIMEOUT itself since it saturates there.
  localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  mem_state_t         r_state;
  mem_state_t         w_next_state;
  logic [c_CNT_W-1:0] r_cnt;

  // Request fields captured when an access is launched.
  logic               r_we;
  logic               r_wreg;
  logic [DW-1:0]      r_addr;
  logic [DW-1:0]      r_wdata;
  logic [3:0]         r_be;
  logic [RW-1:0]      r_dest;
  extnd_sel_t         r_sel;
  logic [1:0]         r_off;

  logic               r_wb_wreg;
  logic [RW-1:0]      r_wb_dest;
  logic [DW-1:0]      r_wb_data;
  logic               r_err;

  extnd_sel_t         w_sel;
  logic               w_memop;
  logic               w_misalign;
  logic               w_start;
  logic               w_last;
  logic               w_timeout;
  logic               w_err_evt;
  logic               w_stall;
  logic               w_req;
  logic [DW-1:0]      w_wdata_rep;
  logic [DW-1:0]      w_load_data;

  assign w_sel      = extnd_sel_t'(extnd_sel_i);
  assign w_memop    = rmem_i | wmem_i;
  assign w_misalign = is_misaligned(w_sel, addr_i[1:0]);
  assign w_start    = (r_state == IDLE) && w_memop && !w_misalign;
  // Final permitted ACCESS cycle; an ack here still counts as success.
  assign w_last     = (r_state == ACCESS) && (r_cnt == c_CNT_LAST);
  assign w_timeout  = w_last && !mem.mem_ack_i;
  assign w_err_evt  = ((r_state == IDLE) && w_memop && (w_misalign || (rmem_i && wmem_i)))
                    || w_timeout;

  // Lane-replicate store data so every enabled byte lane carries the value.
  always_comb begin
    w_wdata_rep = wdata_i;
    case (w_sel)
      EXT_BYTE_U, EXT_BYTE_S: w_wdata_rep = {(DW/8){wdata_i[7:0]}};
      EXT_HALF_S:             w_wdata_rep = {(DW/16){wdata_i[15:0]}};
      default:                w_wdata_rep = wdata_i;
    endcase
  end

  // Next-state and handshake outputs of the access FSM.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next_state = ACCESS;
          w_stall      = 1'b1;
        end
      end
      ACCESS: begin
        w_req   = 1'b1;
        w_stall = !mem.mem_ack_i && !w_last;
        if (mem.mem_ack_i || w_last) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // ACCESS cycle counter: cleared on launch, saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == ACCESS) && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  // Capture the request so the memory port stays stable while upstream changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_wreg  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_dest  <= '0;
      r_sel   <= EXT_WORD;
      r_off   <= 2'b00;
    end else if (w_start) begin
      r_we    <= wmem_i;
      r_wreg  <= wreg_i;
      r_addr  <= {addr_i[DW-1:2], 2'b00};
      r_wdata <= w_wdata_rep;
      r_be    <= byte_enables(w_sel, addr_i[1:0]);
      r_dest  <= dest_i;
      r_sel   <= w_sel;
      r_off   <= addr_i[1:0];
    end
  end

  load_extend #(
    .DW(DW)
  ) u_load_extend (
    .rdata     (mem.mem_rdata_i),
    .offset    (r_off),
    .extnd_sel (r_sel),
    .ext_data  (w_load_data)
  );

  // Writeback bundle: pass-through in IDLE, load result on ack, else no write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_wreg <= 1'b0;
      r_wb_dest <= '0;
      r_wb_data <= '0;
    end else if (r_state == IDLE) begin
      if (!w_memop) begin
        r_wb_wreg <= wreg_i;
        r_wb_dest <= dest_i;
        r_wb_data <= addr_i;
      end else begin
        r_wb_wreg <= 1'b0;
      end
    end else if (mem.mem_ack_i) begin
      if (r_we) begin
        r_wb_wreg <= 1'b0;
      end else begin
        r_wb_wreg <= r_wreg;
        r_wb_dest <= r_dest;
        r_wb_data <= w_load_data;
      end
    end else if (w_last) begin
      r_wb_wreg <= 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  // Stall is forced low while reset is held so upstream is released at once.
  assign stall_o         = w_stall & ~rst;
  assign mem.mem_req_o   = w_req;
  assign mem.mem_we_o    = r_we;
  assign mem.mem_addr_o  = r_addr;
  assign mem.mem_wdata_o = r_wdata;
  assign mem.mem_be_o    = r_be;
  assign wb_wreg_o       = r_wb_wreg;
  assign wb_dest_o       = r_wb_dest;
  assign wb_data_o       = r_wb_data;
  assign err_o           = r_err;

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

- Memory-stage controller of the CPU pipeline; sits directly downstream of the EX/MEM pipeline register and consumes its control/data outputs.
- Performs loads and stores over a req/ack data-memory port, applies byte-lane selection and load extension, and asserts `stall_o` upstream while an access is outstanding.
- Drives a registered writeback bundle toward the MEM/WB stage.

## Interface
Parameters:
- `DW`, 32: data and address width.
- `RW`, 4: register index width.
- `TIMEOUT`, 16: maximum cycles in ACCESS waiting for ack; minimum 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wmem_i`  in  1  store request from EX/MEM.
- `rmem_i`  in  1  load request from EX/MEM.
- `wreg_i`  in  1  instruction writes a register.
- `addr_i`  in  DW  ALU result, used as the memory address or as a pass-through result.
- `wdata_i`  in  DW  store data.
- `dest_i`  in  RW  destination register index.
- `extnd_sel_i`  in  2  access size: 00 word, 01 byte zero-extend, 10 byte sign-extend, 11 half sign-extend.
- `stall_o`  out  1  hold the EX/MEM register and all earlier stages.
- `mem_req_o`  out  1  memory request.
- `mem_we_o`  out  1  1 means write.
- `mem_addr_o`  out  DW  word-aligned address (`addr_i` with bits [1:0] forced to 0).
- `mem_wdata_o`  out  DW  lane-replicated store data.
- `mem_be_o`  out  4  byte enables.
- `mem_ack_i`  in  1  memory done; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  DW  read data.
- `wb_wreg_o`  out  1  registered writeback enable.
- `wb_dest_o`  out  RW  registered destination index.
- `wb_data_o`  out  DW  registered writeback value.
- `err_o`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE, no memory op** (`rmem_i` = `wmem_i` = 0):
  - `wb_*` load `wreg_i`, `dest_i`, `addr_i` at the next edge.
  - `stall_o` = 0.
- **IDLE, memory op, aligned:**
  - `stall_o` = 1 combinationally.
  - The request fields are captured into internal registers; go to ACCESS.
  - `wb_wreg_o` loads 0 at that edge.
- **Both `rmem_i` and `wmem_i` set:** treated as a store, and `err_o` is set.
- **Misaligned** (word with `addr[1:0]`≠0, or half with `addr[0]`=1):
  - No request is issued; `err_o` is set.
  - `wb_wreg_o` loads 0; `stall_o` = 0; stay in IDLE.
- **ACCESS:**
  - `mem_req_o` = 1; `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are driven from the captured registers and held stable until ack.
  - `stall_o` = !`mem_ack_i`.
- **On ack:**
  - Return to IDLE.
  - Load: `wb_wreg_o` ← captured wreg, `wb_dest_o` ← captured dest, `wb_data_o` ← extended rdata.
  - Store: `wb_wreg_o` ← 0.
- **Timeout:** if ack has not arrived after `TIMEOUT` cycles in ACCESS:
  - Drop `mem_req_o`, set `err_o`, return to IDLE.
  - `wb_wreg_o` ← 0; `stall_o` = 0 in the final timeout cycle.
- **Byte enables:**
  - Word: 1111.
  - Byte: 0001 << `addr[1:0]`.
  - Half: 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
- **Store data replication:**
  - Byte: `wdata[7:0]` replicated ×4.
  - Half: `wdata[15:0]` replicated ×2.
- **Load extension:** select the lane using `addr[1:0]`, then zero- or sign-extend to DW as selected by `extnd_sel_i`.

## Timing
- **Reset values:** `stall_o` 0; `mem_req_o` 0; `mem_we_o` 0; `mem_addr_o` 0; `mem_wdata_o` 0; `mem_be_o` 0; all `wb_*` 0; `err_o` 0; state IDLE; timeout counter 0.
- **Pass-through latency:** 1 cycle.
- **Memory op latency:** capture edge, then N ACCESS cycles (N ≥ 1, ack in cycle N), then `wb_*` valid after the edge ending cycle N.
- **Back-to-back ops:**
  - Ack cycle has `stall_o` = 0, so the next instruction is presented in the first cycle after the ack edge.
  - There is no dead cycle after a non-memory op.
- **Ack rules:**
  - `mem_ack_i` in IDLE is ignored.
  - An ack arriving in the same cycle the counter reaches `TIMEOUT` counts as success.
- **Timeout counter:**
  - Width `$clog2(TIMEOUT+1)`.
  - Cleared on entry to ACCESS; does not wrap.
- **`rst` mid-ACCESS:** `mem_req_o` and `stall_o` drop asynchronously, and the in-flight op is discarded.
- **`err_o`:** set on the edge ending the error cycle; cleared only by `rst`.

## Structure
- Shared package `cpu_mem_pkg`:
  - `extnd_sel_t` enum: `EXT_WORD`, `EXT_BYTE_U`, `EXT_BYTE_S`, `EXT_HALF_S`.
  - `mem_state_t` enum: IDLE, ACCESS.
- Sub-module `load_extend`:
  - Combinational; inputs `rdata`, `offset[1:0]`, `extnd_sel`; output the extended DW value.
  - Reused by the forwarding logic.

## Test plan
- **Pass-through:** `wreg_i`=1, `dest_i`=5, `addr_i`=0x1234, no memory op → next cycle `wb_wreg_o`=1, `wb_dest_o`=5, `wb_data_o`=0x1234, `stall_o` always 0.
- **Signed byte load:** `rmem_i`, addr 0x103, sel 10, ack after 3 cycles with rdata 0x80AABBCC:
  - `mem_addr_o`=0x100, `mem_be_o`=1000.
  - `stall_o` high for 3 cycles (including capture cycle, low on ack).
  - `wb_data_o`=0xFFFFFF80.
- **Half store:** `wmem_i`, addr 0x22, sel 11, wdata 0x0000BEEF, ack in first ACCESS cycle → `mem_we_o`=1, `mem_be_o`=1100, `mem_wdata_o`=0xBEEFBEEF, `wb_wreg_o`=0.
- **Misaligned word load:** addr 0x2 → no `mem_req_o`, `err_o`=1 from next cycle, `wb_wreg_o`=0, `stall_o` 0.
- **Timeout:** `TIMEOUT`=4, no ack → `mem_req_o` high exactly 4 cycles, then `err_o`=1, state IDLE; a subsequent word load with immediate ack completes normally.
- **Reset during ACCESS:** assert `rst` during cycle 2 of ACCESS → `mem_req_o`, `stall_o` and `wb_*` are 0 immediately; after release, a word load of 0x40 returns ack data unchanged.
